touch_mode_selector: RTL and testbench

Touch-driven display-mode selector for the photo/smiley display path. It sits between the touch panel controller (IRQ plus serial coordinate results) and the display mux. It steps a mode index forward or backward depending on which side of the panel was touched, and wraps modulo a parametrised mode count. A hold-off window suppresses bounce and repeats, and a long press returns the index to a home mode.

---
 rtl/touch_mode_selector.sv | 174 +++++++++++++++++
 tb/tb_touch_mode_selector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/touch_mode_selector.sv
// Touch-driven display-mode selector: steps a wrapping mode index forward/backward
// by touch side, with bounce hold-off and long-press return to the home mode.
module touch_mode_selector #(
    parameter int                   MODE_W         = 2,
    parameter int                   NUM_MODES      = 4,
    parameter int                   COORD_W        = 12,
    parameter logic [COORD_W-1:0]   X_SPLIT        = 12'd2048,
    parameter int                   CNT_W          = 25,
    parameter logic [CNT_W-1:0]     COORD_TIMEOUT  = 25'd100000,
    parameter logic [CNT_W-1:0]     HOLDOFF_CNT    = 25'hFFFFFF,
    parameter logic [CNT_W-1:0]     LONG_PRESS_CNT = 25'h17D7840,
    parameter int                   HOME_MODE      = 0
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic               iTOUCH_IRQ,
    input  logic [COORD_W-1:0] iX_COORD,
    input  logic [COORD_W-1:0] iY_COORD,
    input  logic               iNEW_COORD,
    output logic [MODE_W-1:0]  oDISPLAY_MODE,
    output logic               oMODE_CHANGED,
    output logic               oLONG_PRESS,
    output logic               oBUSY
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_COORD = 2'd1,
        ST_HOLDOFF    = 2'd2
    } state_t;

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] HOME      = MODE_W'(HOME_MODE);
    localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  TMO_LAST  = COORD_TIMEOUT - CNT_ONE;
    localparam logic [CNT_W-1:0]  LP_LAST   = LONG_PRESS_CNT - CNT_ONE;

    function automatic logic [MODE_W-1:0] mode_fwd(input logic [MODE_W-1:0] m);
        if (m == LAST_MODE) begin
            return '0;
        end else begin
            return m + MODE_ONE;
        end
    endfunction

    function automatic logic [MODE_W-1:0] mode_bwd(input logic [MODE_W-1:0] m);
        if (m == '0) begin
            return LAST_MODE;
        end else begin
            return m - MODE_ONE;
        end
    endfunction

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   timer_r, timer_nxt_s;
    logic [CNT_W-1:0]   press_r, press_nxt_s;
    logic [MODE_W-1:0]  mode_r, mode_nxt_s;
    logic               changed_r, changed_nxt_s;
    logic               long_r, long_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               step_s, step_fwd_s;

    // Y coordinate is carried on the port but not used by this block
    logic unused_s;
    assign unused_s = ^iY_COORD;

    // Next-state, timers, step decision and mode update
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        press_nxt_s   = press_r;
        mode_nxt_s    = mode_r;
        changed_nxt_s = 1'b0;
        long_nxt_s    = 1'b0;
        step_s        = 1'b0;
        step_fwd_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (iTOUCH_IRQ) begin
                    state_nxt_s = ST_WAIT_COORD;
                    timer_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_COORD: begin
                // A coordinate in the timeout cycle still decides direction
                if (iNEW_COORD) begin
                    step_s      = 1'b1;
                    step_fwd_s  = (iX_COORD >= X_SPLIT);
                    state_nxt_s = ST_HOLDOFF;
                    timer_nxt_s = CNT_ZERO;
                end else if (timer_r == TMO_LAST) begin
                    step_s      = 1'b1;
                    step_fwd_s  = 1'b1;
                    state_nxt_s = ST_HOLDOFF;
                    timer_nxt_s = CNT_ZERO;
                end else begin
                    timer_nxt_s = timer_r + CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (timer_r != HOLDOFF_CNT) begin
                    timer_nxt_s = timer_r + CNT_ONE;
                end else begin
                    timer_nxt_s = timer_r;
                end
                if ((timer_r == HOLDOFF_CNT) && !iTOUCH_IRQ) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLDOFF;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = CNT_ZERO;
            end
        endcase

        // Press counter saturates past the trigger so only one long press fires per touch
        if ((state_r == ST_IDLE) || !iTOUCH_IRQ) begin
            press_nxt_s = CNT_ZERO;
        end else if (press_r == LP_LAST) begin
            long_nxt_s  = 1'b1;
            press_nxt_s = LONG_PRESS_CNT;
        end else if (press_r != LONG_PRESS_CNT) begin
            press_nxt_s = press_r + CNT_ONE;
        end else begin
            press_nxt_s = press_r;
        end

        if (long_nxt_s) begin
            mode_nxt_s    = HOME;
            changed_nxt_s = (mode_r != HOME);
        end else if (step_s) begin
            mode_nxt_s    = step_fwd_s ? mode_fwd(mode_r) : mode_bwd(mode_r);
            changed_nxt_s = 1'b1;
        end else begin
            mode_nxt_s    = mode_r;
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r   <= ST_IDLE;
            timer_r   <= CNT_ZERO;
            press_r   <= CNT_ZERO;
            mode_r    <= HOME;
            changed_r <= 1'b0;
            long_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            press_r   <= press_nxt_s;
            mode_r    <= mode_nxt_s;
            changed_r <= changed_nxt_s;
            long_r    <= long_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign oDISPLAY_MODE = mode_r;
    assign oMODE_CHANGED = changed_r;
    assign oLONG_PRESS   = long_r;
    assign oBUSY         = busy_r;

endmodule

// File: tb/tb_touch_mode_selector.sv
// Scoreboard bench for touch_mode_selector: stimulus queues expected mode events,
// a negedge monitor pops and compares them whenever a change or long-press pulse appears.
module tb_touch_mode_selector;

    localparam int TMO = 8;
    localparam int LP  = 40;

    typedef struct {
        logic [1:0] mode;
        logic       chg;
        logic       lp;
        int         cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        irq;
    logic [11:0] x;
    logic [11:0] y;
    logic        new_coord;
    logic [1:0]  mode;
    logic        changed;
    logic        long_press;
    logic        busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    touch_mode_selector #(
        .MODE_W         (2),
        .NUM_MODES      (3),
        .COORD_W        (12),
        .X_SPLIT        (12'd2048),
        .CNT_W          (25),
        .COORD_TIMEOUT  (25'd8),
        .HOLDOFF_CNT    (25'd16),
        .LONG_PRESS_CNT (25'd40),
        .HOME_MODE      (0)
    ) dut (
        .iCLK          (clk),
        .iRST_n        (rst_n),
        .iTOUCH_IRQ    (irq),
        .iX_COORD      (x),
        .iY_COORD      (y),
        .iNEW_COORD    (new_coord),
        .oDISPLAY_MODE (mode),
        .oMODE_CHANGED (changed),
        .oLONG_PRESS   (long_press),
        .oBUSY         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: every change/long-press pulse must match the next queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (changed || long_press)) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL sb_unexpected mode=%0d chg=%0d lp=%0d cyc=%0d (no event expected)",
                             mode, changed, long_press, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (mode !== e.mode || changed !== e.chg || long_press !== e.lp || cyc != e.cyc) begin
                        failures = failures + 1;
                        $display("FAIL sb_event actual mode=%0d chg=%0d lp=%0d cyc=%0d expected mode=%0d chg=%0d lp=%0d cyc=%0d",
                                 mode, changed, long_press, cyc, e.mode, e.chg, e.lp, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One touch: IRQ high for irq_len edges from the IDLE->WAIT edge (k=0), optional
    // coordinate at k=1, optional stray coordinate at k=ho_coord during hold-off.
    task automatic touch(input string nm, input logic [11:0] xv, input bit send,
                         input int irq_len, input int ho_coord, input logic [1:0] exp_mode,
                         input bit exp_long, input int exp_fall);
        int   k;
        int   step_at;
        int   c0;
        exp_t e;
        irq = 1'b1;
        tick();
        c0      = cyc;
        k       = 0;
        step_at = send ? 1 : TMO;
        e.mode = exp_mode; e.chg = 1'b1; e.lp = 1'b0; e.cyc = c0 + step_at;
        exp_q.push_back(e);
        if (exp_long) begin
            e.chg = 1'b0; e.lp = 1'b1; e.cyc = c0 + LP;
            exp_q.push_back(e);
        end
        while (k < 200) begin
            if (k + 1 >= irq_len) irq = 1'b0;
            if (send && (k + 1 == 1)) begin
                x = xv; new_coord = 1'b1;
            end else if (k + 1 == ho_coord) begin
                x = (xv >= 12'd2048) ? 12'd100 : 12'd3000; new_coord = 1'b1;
            end else begin
                new_coord = 1'b0;
            end
            tick();
            k = k + 1;
            if (k == step_at) chk({nm, "_step_mode"}, int'(mode), int'(exp_mode));
            if ((k > step_at) && !busy) break;
        end
        new_coord = 1'b0;
        irq       = 1'b0;
        chk({nm, "_busy_fall_edge"}, k, exp_fall);
        chk({nm, "_final_mode"}, int'(mode), int'(exp_mode));
        tick();
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; irq = 1'b0; x = 12'd0; y = 12'd5; new_coord = 1'b0;
        repeat (3) tick();
        chk("reset_mode", int'(mode), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_changed", int'(changed), 0);
        chk("reset_long", int'(long_press), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        touch("fwd1", 12'd3000, 1'b1, 5, -1, 2'd1, 1'b0, 18);
        touch("fwd2", 12'd3000, 1'b1, 5, -1, 2'd2, 1'b0, 18);
        touch("fwd3", 12'd3000, 1'b1, 5, -1, 2'd0, 1'b0, 18);
        touch("bwd",  12'd100,  1'b1, 5, -1, 2'd2, 1'b0, 18);
        touch("tmo",  12'd0,    1'b0, 3, -1, 2'd0, 1'b0, 25);
        touch("held", 12'd3000, 1'b1, 30, 5, 2'd1, 1'b0, 30);
        touch("fwd4", 12'd3000, 1'b1, 5, -1, 2'd2, 1'b0, 18);
        touch("long", 12'd3000, 1'b1, 60, -1, 2'd0, 1'b1, 60);

        // Reset in the middle of hold-off after stepping 0 -> 1
        irq = 1'b1;
        tick();
        e.mode = 2'd1; e.chg = 1'b1; e.lp = 1'b0; e.cyc = cyc + 1;
        exp_q.push_back(e);
        x = 12'd3000; new_coord = 1'b1;
        tick();
        new_coord = 1'b0; irq = 1'b0;
        repeat (4) tick();
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_mode", int'(mode), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_mode", int'(mode), 0);
        chk("rst_async_busy", int'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", int'(busy), 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
